breadboard_sweep: RTL and testbench
===================================

BREADBOARD_SWEEP -- requirements
Module: breadboard_sweep

Interface
REQ-001 Parameter N_IN, default 4: number of function inputs; legal range 2..6.
REQ-002 Parameter N_OUT, default 10: number of programmable output functions; legal range 1..16.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cfg_we  input  1  truth-table write strobe.
REQ-006 cfg_addr  input  4  function index being written.
REQ-007 cfg_data  input  2^N_IN  full truth table for one function; bit r = output value for input row r.
REQ-008 cfg_err  output  1  sticky flag: illegal configuration write attempted.
REQ-009 start  input  1  one-cycle request to begin a sweep.
REQ-010 skip_zero  input  1  sweep mode; 1 = suppress rows where all outputs are 0; sampled when start is accepted.
REQ-011 row_valid  output  1  current row presented.
REQ-012 row_ready  input  1  consumer accepts the presented row.
REQ-013 row_idx  output  N_IN  input combination of the presented row (MSB = highest input).
REQ-014 row_out  output  N_OUT  function outputs for row_idx; bit k = function k.
REQ-015 busy  output  1  sweep in progress.
REQ-016 done  output  1  one-cycle pulse at sweep completion.
REQ-017 row_count  output  N_IN+1  rows handed over in the current or last sweep.

Function
REQ-018 The block SHALL hold N_OUT table entries of 2^N_IN bits each.
REQ-019 When cfg_we=1, busy=0 and cfg_addr<N_OUT, entry cfg_addr SHALL take cfg_data at that edge.
REQ-020 A write with cfg_addr>=N_OUT or busy=1 SHALL be ignored and SHALL set cfg_err, which stays set until rst.
REQ-021 row_out[k] SHALL equal table[k][row_idx] whenever row_valid=1.
REQ-022 The FSM SHALL have states IDLE, SWEEP and DONE.
REQ-023 IDLE + start: go to SWEEP; cursor=0; row_count=0; latch skip_zero; busy=1 from the next cycle.
REQ-024 start while busy=1 or in DONE SHALL be ignored.
REQ-025 SWEEP, cursor row all-zero and skip latched: keep row_valid=0; advance cursor one row per cycle.
REQ-026 SWEEP, otherwise: row_valid=1 with row_idx=cursor.
REQ-027 A presented row SHALL be held stable with no retraction while row_ready=0.
REQ-028 Handshake (row_valid & row_ready): row_count increments and cursor advances at that edge.
REQ-029 Throughput SHALL be one row per cycle while row_ready=1.
REQ-030 Once the last row (2^N_IN-1) is handed over or skipped: go to DONE; row_valid=0.
REQ-031 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE.
REQ-032 row_count SHALL hold its final value until the next accepted start.
REQ-033 Latency: start accepted at edge 0 gives the first row valid in cycle 1; full sweep with row_ready=1 gives done in cycle 2^N_IN+1.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 rst=1 at any edge, including mid-sweep, SHALL force IDLE and clear the table, cfg_err, row_valid, row_idx, row_out, busy, done and row_count to 0.
REQ-036 Writes and start SHALL be ignored in any cycle with rst=1.

Verification
REQ-037 Reset: rst high 2 cycles -> every output 0, busy 0; start with empty table, skip_zero=1 -> no rows, done in cycle 17, row_count=0.
REQ-038 Full sweep: write entry 0 = 0xFAC8, start, skip_zero=0, row_ready=1 -> rows 0..15 in cycles 1..16; row_out[0] = bit r of 0xFAC8; done in cycle 17; row_count=16.
REQ-039 Skip mode: same table, skip_zero=1 -> rows handed over are exactly 3,6,7,9,11,12,13,14,15 in order; row_count=9.
REQ-040 Backpressure: row_ready=0 for 3 cycles while row 5 is presented -> row_idx=5 and row_out stay stable; no row lost or duplicated; final row_count=16.
REQ-041 Config errors: write cfg_addr=12 -> cfg_err=1, table unchanged; write entry 1 mid-sweep -> ignored, rows keep old data.
REQ-042 Mid-sweep reset: rst at row 7 -> next cycle row_valid=0, busy=0, row_count=0; new sweep gives all-zero row_out.

Source files
------------

// File: rtl/breadboard_sweep.sv
// Programmable truth-table breadboard.
// Walks every input row and streams the function outputs out.
module breadboard_sweep #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_addr,
  input  logic [2**N_IN-1:0]   cfg_data,
  output logic                 cfg_err,
  input  logic                 start,
  input  logic                 skip_zero,
  output logic                 row_valid,
  input  logic                 row_ready,
  output logic [N_IN-1:0]      row_idx,
  output logic [N_OUT-1:0]     row_out,
  output logic                 busy,
  output logic                 done,
  output logic [N_IN:0]        row_count
);

  localparam int ROWS = 2**N_IN;
  localparam logic [N_IN-1:0] LAST = N_IN'(ROWS-1);
  localparam logic [N_IN:0] CNT_ONE = (N_IN+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [ROWS-1:0] table_q [N_OUT];
  logic [N_IN-1:0] cur_q, cur_d;
  logic            skip_q, skip_d;
  logic            valid_q, valid_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_OUT-1:0] out_q, out_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [N_IN:0]   cnt_q, cnt_d;
  logic            err_q;

  logic            addr_ok;
  logic            wr_ok;
  logic [N_IN-1:0] nxt_row;
  logic [N_OUT-1:0] nxt_col;
  logic            load;

  assign addr_ok = {1'b0, cfg_addr} < 5'(N_OUT);
  assign wr_ok   = cfg_we && !busy_q && addr_ok;

  // Row to evaluate next: row 0 on start, else the successor.
  always_comb begin
    nxt_row = (state_q == IDLE) ? '0 : cur_q + 1'b1;
  end

  always_comb begin
    nxt_col = '0;
    for (int k = 0; k < N_OUT; k++) begin
      nxt_col[k] = table_q[k][nxt_row];
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    skip_d  = skip_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SWEEP;
          skip_d  = skip_zero;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      SWEEP: begin
        if (valid_q && row_ready) begin
          cnt_d = cnt_q + CNT_ONE;
        end
        // A skipped row never waits on the consumer.
        if (!valid_q || row_ready) begin
          if (cur_q == LAST) begin
            state_d = DONE;
            valid_d = 1'b0;
          end else begin
            load = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (load) begin
      cur_d   = nxt_row;
      idx_d   = nxt_row;
      out_d   = nxt_col;
      valid_d = !(skip_d && (nxt_col == '0));
    end
    busy_d = (state_d == SWEEP);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      skip_q  <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      skip_q  <= skip_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      if (cfg_we && !wr_ok) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_OUT; k++) begin
        table_q[k] <= '0;
      end
    end else if (wr_ok) begin
      table_q[cfg_addr] <= cfg_data;
    end
  end

  assign cfg_err   = err_q;
  assign row_valid = valid_q;
  assign row_idx   = idx_q;
  assign row_out   = out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign row_count = cnt_q;

endmodule

// File: tb/tb_breadboard_sweep.sv
// Directed bench for breadboard_sweep.
// Drives sweeps with a small truth-table model as reference.
module tb_breadboard_sweep;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        cfg_err;
  logic        start = 1'b0;
  logic        skip_zero = 1'b0;
  logic        row_valid;
  logic        row_ready = 1'b1;
  logic [3:0]  row_idx;
  logic [9:0]  row_out;
  logic        busy;
  logic        done;
  logic [4:0]  row_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] tb_tab [10];
  int          got_idx [$];
  logic [9:0]  got_out [$];
  int          exp_skip [9] = '{3, 6, 7, 9, 11, 12, 13, 14, 15};
  int          dcyc;

  breadboard_sweep #(.N_IN(4), .N_OUT(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err),
    .start     (start),
    .skip_zero (skip_zero),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_idx   (row_idx),
    .row_out   (row_out),
    .busy      (busy),
    .done      (done),
    .row_count (row_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] mcol(input int r);
    logic [9:0] c;
    for (int k = 0; k < 10; k++) c[k] = tb_tab[k][r];
    return c;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 10; k++) tb_tab[k] = '0;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    cfg_addr = a;
    cfg_data = d;
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
    if (a < 4'd10) tb_tab[a] = d;
  endtask

  task automatic sweep(input logic s, input int srow, input int sn,
                       input int wrow, output int dc);
    int cyc;
    int left;
    logic held;
    logic [3:0] hidx;
    logic [9:0] hout;
    got_idx.delete();
    got_out.delete();
    left = sn;
    held = 1'b0;
    hidx = '0;
    hout = '0;
    skip_zero = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 100 && done !== 1'b1) begin
      chk("busy_run", 32'(busy), 1);
      if (held) begin
        chk("hold_valid", 32'(row_valid), 1);
        chk("hold_idx", 32'(row_idx), 32'(hidx));
        chk("hold_out", 32'(row_out), 32'(hout));
      end
      held = 1'b0;
      if (row_valid && int'(row_idx) == srow && left > 0) begin
        row_ready = 1'b0;
        left--;
        held = 1'b1;
        hidx = row_idx;
        hout = row_out;
      end else begin
        row_ready = 1'b1;
      end
      cfg_we = row_valid && int'(row_idx) == wrow;
      if (row_valid && row_ready) begin
        got_idx.push_back(int'(row_idx));
        got_out.push_back(row_out);
      end
      tick();
      cyc++;
    end
    cfg_we = 1'b0;
    row_ready = 1'b1;
    dc = cyc;
    chk("done_seen", 32'(done), 1);
    chk("busy_at_done", 32'(busy), 0);
    chk("valid_at_done", 32'(row_valid), 0);
    chk("count_at_done", 32'(row_count), 32'(got_idx.size()));
    tick();
    chk("done_pulse", 32'(done), 0);
    chk("count_hold", 32'(row_count), 32'(got_idx.size()));
  endtask

  task automatic chk_rows(input logic s);
    int exp_idx [$];
    for (int r = 0; r < 16; r++) begin
      if (!(s && mcol(r) == '0)) exp_idx.push_back(r);
    end
    chk("rows_n", 32'(got_idx.size()), 32'(exp_idx.size()));
    for (int i = 0; i < got_idx.size() && i < exp_idx.size(); i++) begin
      chk("row_idx", 32'(got_idx[i]), 32'(exp_idx[i]));
      chk("row_out", 32'(got_out[i]), 32'(mcol(exp_idx[i])));
    end
  endtask

  initial begin
    int guard;
    clear_model();

    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(row_valid), 0);
    chk("rst_idx", 32'(row_idx), 0);
    chk("rst_out", 32'(row_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(row_count), 0);
    chk("rst_err", 32'(cfg_err), 0);
    rst = 1'b0;

    sweep(1'b1, -1, 0, -1, dcyc);
    chk("empty_done_cyc", 32'(dcyc), 17);
    chk("empty_count", 32'(got_idx.size()), 0);

    cfg_write(4'd0, 16'hFAC8);
    chk("err_after_ok", 32'(cfg_err), 0);

    sweep(1'b0, -1, 0, -1, dcyc);
    chk("full_done_cyc", 32'(dcyc), 17);
    chk("full_count", 32'(got_idx.size()), 16);
    chk_rows(1'b0);

    sweep(1'b1, -1, 0, -1, dcyc);
    chk("skip_count", 32'(got_idx.size()), 9);
    for (int i = 0; i < 9 && i < got_idx.size(); i++) begin
      chk("skip_list", 32'(got_idx[i]), 32'(exp_skip[i]));
    end
    chk_rows(1'b1);

    sweep(1'b0, 5, 3, -1, dcyc);
    chk("bp_done_cyc", 32'(dcyc), 20);
    chk("bp_count", 32'(got_idx.size()), 16);
    chk_rows(1'b0);

    cfg_addr = 4'd1;
    cfg_data = 16'hFFFF;
    sweep(1'b0, -1, 0, 3, dcyc);
    chk("midwr_err", 32'(cfg_err), 1);
    chk_rows(1'b0);
    sweep(1'b0, -1, 0, -1, dcyc);
    chk_rows(1'b0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    chk("err_cleared", 32'(cfg_err), 0);
    cfg_write(4'd0, 16'hFAC8);
    cfg_write(4'd12, 16'hFFFF);
    chk("addr12_err", 32'(cfg_err), 1);
    sweep(1'b0, -1, 0, -1, dcyc);
    chk_rows(1'b0);

    skip_zero = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (guard < 50 && !(row_valid && row_idx == 4'd7)) begin
      tick();
      guard++;
    end
    chk("reach_row7", 32'(row_idx), 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    chk("mrst_valid", 32'(row_valid), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_count", 32'(row_count), 0);
    chk("mrst_err", 32'(cfg_err), 0);
    sweep(1'b0, -1, 0, -1, dcyc);
    chk("mrst_sweep_n", 32'(got_idx.size()), 16);
    chk_rows(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
